// File: rtl/instr_dispatch_ctrl.sv
// instr_dispatch_ctrl
//   Instruction sequencer. Fetches one instruction word at a time, decodes its opcode,
//   issues a single-cycle one-hot activate to the ALU, memory or branch unit and then waits
//   for that unit's done before moving on. Opcode 4'hF parks the block in HALT until reset.
//
//   Optional feature: define DISPATCH_TIMEOUT_EN to add a WAIT watchdog. After TIMEOUT_CYC
//   WAIT cycles without the selected done, err is set (sticky) and the block halts.
//   With the macro undefined WAIT is unbounded and err is tied low.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   go           level; starts fetching from IDLE and chooses FETCH/IDLE after RETIRE
//   instr_req    fetch request, high for the whole FETCH state
//   instr_valid  instr_data qualifier, only honoured in FETCH
//   instr_data   instruction word: opcode [15:12], param1 [11:6], param2 [5:0]
//   opcode       latched opcode field
//   param1       latched param1 field
//   param2       latched param2 field
//   unit_act     one-hot activate pulse: [0] ALU, [1] MEM, [2] BRANCH
//   unit_done    per-unit done, same bit order as unit_act
//   busy         high in every state except IDLE and HALT
//   halted       high in HALT
//   err          sticky watchdog flag
module instr_dispatch_ctrl #(
    parameter int unsigned INSTR_W     = 16,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    output logic               instr_req,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr_data,
    output logic [3:0]         opcode,
    output logic [5:0]         param1,
    output logic [5:0]         param2,
    output logic [2:0]         unit_act,
    input  logic [2:0]         unit_done,
    output logic               busy,
    output logic               halted,
    output logic               err
);

    // Field slicing is hard-wired to a 16-bit word; the watchdog counter is 7 bits wide.
    if (INSTR_W != 16 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 127) begin : gen_param_check
        $error("instr_dispatch_ctrl: INSTR_W must be 16 and TIMEOUT_CYC in 1..127");
    end

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StAct,
        StBlank,
        StWait,
        StRetire,
        StHalt
    } state_e;

    state_e     state;
    logic [2:0] sel;  // one-hot unit chosen in DECODE, held through WAIT

    function automatic logic [2:0] decode_sel(input logic [3:0] op);
        if (!op[3]) begin
            return 3'b001;
        end else if (op[3:2] == 2'b10) begin
            return 3'b010;
        end else begin
            return 3'b100;
        end
    endfunction

`ifdef DISPATCH_TIMEOUT_EN
    logic [6:0] wait_cnt;
    logic       err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            sel       <= 3'b000;
            instr_req <= 1'b0;
            unit_act  <= 3'b000;
            busy      <= 1'b0;
            halted    <= 1'b0;
            opcode    <= 4'h0;
            param1    <= 6'h00;
            param2    <= 6'h00;
`ifdef DISPATCH_TIMEOUT_EN
            wait_cnt  <= 7'd0;
            err_q     <= 1'b0;
`endif
        end else begin
            // Activate is a pulse: cleared every cycle unless DECODE sets it for ACT.
            unit_act <= 3'b000;
            unique case (state)
                StIdle: begin
                    if (go) begin
                        state     <= StFetch;
                        instr_req <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                StFetch: begin
                    if (instr_valid) begin
                        opcode    <= instr_data[15:12];
                        param1    <= instr_data[11:6];
                        param2    <= instr_data[5:0];
                        instr_req <= 1'b0;
                        state     <= StDecode;
                    end
                end
                StDecode: begin
                    if (opcode == 4'hF) begin
                        state  <= StHalt;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        sel      <= decode_sel(opcode);
                        unit_act <= decode_sel(opcode);
                        state    <= StAct;
                    end
                end
                StAct: begin
                    state <= StBlank;
                end
                StBlank: begin
                    // A done left over from the previous op may still be high here.
                    state <= StWait;
`ifdef DISPATCH_TIMEOUT_EN
                    wait_cnt <= 7'd0;
`endif
                end
                StWait: begin
                    if ((unit_done & sel) != 3'b000) begin
                        state <= StRetire;
`ifdef DISPATCH_TIMEOUT_EN
                    end else if (wait_cnt == 7'(TIMEOUT_CYC - 1)) begin
                        err_q  <= 1'b1;
                        state  <= StHalt;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 7'd1;
`endif
                    end
                end
                StRetire: begin
                    if (go) begin
                        state     <= StFetch;
                        instr_req <= 1'b1;
                    end else begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                StHalt: begin
                    state <= StHalt;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
